fsm_run_tx: RTL

Serial run-length transmitter. It accepts (bit value, run length) commands over a valid/ready handshake and drives them bit-serially on W, one bit per clock. This makes it the generating end of the 4-equal-bit run detector line. It also outputs EXP_S, a cycle-accurate prediction of the detector's acceptance flag, so benches and self-test logic can scoreboard the detector directly.

---
 rtl/fsm_run_tx.sv | 92 +++++++++
 1 files changed

// File: rtl/fsm_run_tx.sv
// Serial run-length transmitter: (bit, length) commands in, one W bit per clock out, with a predicted run-detector flag.
// Latency: first bit on W one cycle after the accepting edge; a run of L bits ends with DONE on its last bit.
// Backpressure: IN_READY is high only in idle or on the last bit of a run, so consecutive runs chain with no gap.
module fsm_run_tx #(
    parameter int LEN_W      = 4,
    parameter bit IDLE_BIT   = 1'b0,
    parameter int ACCEPT_RUN = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IN_BIT,
    input  logic [LEN_W-1:0] IN_LEN,
    output logic             W,
    output logic             W_EN,
    output logic             DONE,
    output logic [2:0]       RUN,
    output logic             EXP_S
);

    localparam logic [2:0]       ACC_RUN = 3'(ACCEPT_RUN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             bit_q, bit_nxt;
    logic             accept;
    logic             w_nxt, done_nxt;
    logic [2:0]       run_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            bit_q <= 1'b0;
            W     <= IDLE_BIT;
            W_EN  <= 1'b0;
            DONE  <= 1'b0;
            RUN   <= 3'd0;
            EXP_S <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bit_q <= bit_nxt;
            W     <= w_nxt;
            W_EN  <= (state_nxt == SEND);
            DONE  <= done_nxt;
            RUN   <= run_nxt;
            EXP_S <= (run_nxt >= ACC_RUN);
        end
    end

    // cnt holds the number of bits still to send, including the one on W now.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_q;
        if (state == SEND) begin
            if (cnt > ONE) begin
                cnt_nxt = cnt - ONE;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
        if (accept && (IN_LEN != '0)) begin
            state_nxt = SEND;
            cnt_nxt   = IN_LEN;
            bit_nxt   = IN_BIT;
        end
    end

    always_comb begin
        IN_READY = !RST && ((state == IDLE) || (cnt == ONE));
        accept   = IN_VALID && IN_READY;
        w_nxt    = (state_nxt == SEND) ? bit_nxt : IDLE_BIT;
        done_nxt = (accept && (IN_LEN == '0)) ||
                   ((state_nxt == SEND) && (cnt_nxt == ONE));
        // Only a change of W restarts the run; run boundaries of equal bits do not.
        if ((RUN == 3'd0) || (w_nxt != W)) begin
            run_nxt = 3'd1;
        end else if (RUN >= ACC_RUN) begin
            run_nxt = ACC_RUN;
        end else begin
            run_nxt = RUN + 3'd1;
        end
    end

endmodule
